// File: rtl/vxe_regs_if.sv
// vxe_regs BIU bus bundle: APB BIU request and registered response.
// master: addr/enable/rnw/wdata out, rdata/accept in; slave: reverse.
interface vxe_regs_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] biu_addr;
  logic                  biu_enable;
  logic                  biu_rnw;
  logic [DATA_WIDTH-1:0] biu_wdata;
  logic [DATA_WIDTH-1:0] biu_rdata;
  logic                  biu_accept;

  modport master (
    output biu_addr, biu_enable, biu_rnw, biu_wdata,
    input  biu_rdata, biu_accept
  );

  modport slave (
    input  biu_addr, biu_enable, biu_rnw, biu_wdata,
    output biu_rdata, biu_accept
  );
endinterface

// File: rtl/vxe_regs.sv
// vxe_regs: engine register block (ID/CTRL/STATUS/MASK/RAW/CMD FIFO).
// Ports: clk, nrst, biu (slave), ev_done/ev_err, eng_busy, ctrl_en,
// start, cmd_valid/cmd_data/cmd_ready, intr.
module vxe_regs #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] ID_VALUE   = 32'h5645_0001
) (
  input  logic                  clk,
  input  logic                  nrst,
  vxe_regs_if.slave             biu,
  input  logic                  ev_done,
  input  logic                  ev_err,
  input  logic                  eng_busy,
  output logic                  ctrl_en,
  output logic                  start,
  output logic                  cmd_valid,
  output logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  cmd_ready,
  output logic                  intr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  acc_q, acc_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ctrl_en_q, ctrl_en_d;
  logic                  start_q, start_d;
  logic [1:0]            mask_q, mask_d;
  logic [1:0]            raw_q, raw_d;
  logic                  intr_q, intr_d;
  logic [2:0]            count_q, count_d;
  logic [1:0]            wptr_q, wptr_d;
  logic [1:0]            rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] mem [4];

  logic [2:0]            sel;
  logic                  hit_id, hit_ctrl, hit_stat;
  logic                  hit_mask, hit_raw, hit_cmd;
  logic                  go, wr, push, pop, full, empty, stall;
  logic [1:0]            w1c;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  unused_addr;

  assign unused_addr = ^{biu.biu_addr[ADDR_WIDTH-1:5],
                         biu.biu_addr[1:0]};

  assign sel      = biu.biu_addr[4:2];
  assign hit_id   = (sel == 3'd0);
  assign hit_ctrl = (sel == 3'd1);
  assign hit_stat = (sel == 3'd2);
  assign hit_mask = (sel == 3'd3);
  assign hit_raw  = (sel == 3'd4);
  assign hit_cmd  = (sel == 3'd5);

  assign full  = count_q[2];
  assign empty = (count_q == 3'd0);
  assign pop   = !empty && cmd_ready;
  // A full FIFO can still take a push in the cycle it is popped.
  assign stall = !biu.biu_rnw && hit_cmd && full && !pop;

  always_comb begin
    rd_val = '0;
    unique case (1'b1)
      hit_id:   rd_val = ID_VALUE;
      hit_ctrl: rd_val[0] = ctrl_en_q;
      hit_stat: rd_val[6:0] = {empty, full, count_q, 1'b0, eng_busy};
      hit_mask: rd_val[1:0] = mask_q;
      hit_raw:  rd_val[1:0] = raw_q;
      default:  rd_val = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = 1'b0;
    rdata_d = rdata_q;
    go      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (biu.biu_enable && !stall) begin
          go      = 1'b1;
          acc_d   = 1'b1;
          rdata_d = biu.biu_rnw ? rd_val : '0;
          state_d = ACK;
        end
      end
      ACK:  state_d = WAIT;
      WAIT: if (!biu.biu_enable) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wr   = go && !biu.biu_rnw;
  assign push = wr && hit_cmd;
  assign w1c  = (wr && hit_raw) ? biu.biu_wdata[1:0] : 2'b00;

  always_comb begin
    ctrl_en_d = ctrl_en_q;
    mask_d    = mask_q;
    if (wr && hit_ctrl) ctrl_en_d = biu.biu_wdata[0];
    if (wr && hit_mask) mask_d = biu.biu_wdata[1:0];
    start_d = wr && hit_ctrl && biu.biu_wdata[1];
    // New events override a same-cycle clear.
    raw_d   = (raw_q & ~w1c) | {ev_err, ev_done};
    intr_d  = |(raw_q & mask_q);
    count_d = count_q + {2'b00, push} - {2'b00, pop};
    wptr_d  = wptr_q + {1'b0, push};
    rptr_d  = rptr_q + {1'b0, pop};
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      acc_q     <= 1'b0;
      rdata_q   <= '0;
      ctrl_en_q <= 1'b0;
      start_q   <= 1'b0;
      mask_q    <= 2'b00;
      raw_q     <= 2'b00;
      intr_q    <= 1'b0;
      count_q   <= 3'd0;
      wptr_q    <= 2'd0;
      rptr_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      rdata_q   <= rdata_d;
      ctrl_en_q <= ctrl_en_d;
      start_q   <= start_d;
      mask_q    <= mask_d;
      raw_q     <= raw_d;
      intr_q    <= intr_d;
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= biu.biu_wdata;
  end

  assign biu.biu_accept = acc_q;
  assign biu.biu_rdata  = rdata_q;
  assign ctrl_en        = ctrl_en_q;
  assign start          = start_q;
  assign intr           = intr_q;
  assign cmd_valid      = !empty;
  assign cmd_data       = mem[rptr_q];

endmodule
